// File: rtl/axi_master_bridge.sv
// axi_master_bridge
// Turns the cache arbiter's level-held burst request/beat interface into AXI4
// master AR/R/AW/W/B channels. The read and write engines run independently.
// Optional build macro: AXI_BRIDGE_ERR_CNT_EN adds a sticky error flag and a
// saturating response-error counter; without it err_o/err_cnt_o are tied low.
module axi_master_bridge #(
  parameter int AXI_ID_W  = 4,
  parameter int RD_ID     = 0,
  parameter int WR_ID     = 1,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce_i,
  // read request / beat return
  input  logic                 ren_i,
  input  logic [31:0]          raddr_i,
  input  logic [7:0]           rlen_i,
  input  logic                 rready_i,
  output logic [31:0]          rdata_o,
  output logic                 rdata_valid_o,
  // write request / current beat
  input  logic                 wen_i,
  input  logic [31:0]          waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           wsel_i,
  input  logic [7:0]           wlen_i,
  input  logic                 wlast_i,
  input  logic                 wvalid_i,
  output logic                 wdata_resp_o,
  // AXI read address
  output logic [AXI_ID_W-1:0]  m_arid,
  output logic [31:0]          m_araddr,
  output logic [7:0]           m_arlen,
  output logic [2:0]           m_arsize,
  output logic [1:0]           m_arburst,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  // AXI read data
  input  logic [AXI_ID_W-1:0]  m_rid,
  input  logic [31:0]          m_rdata,
  input  logic [1:0]           m_rresp,
  input  logic                 m_rlast,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  // AXI write address
  output logic [AXI_ID_W-1:0]  m_awid,
  output logic [31:0]          m_awaddr,
  output logic [7:0]           m_awlen,
  output logic [2:0]           m_awsize,
  output logic [1:0]           m_awburst,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  // AXI write data
  output logic [31:0]          m_wdata,
  output logic [3:0]           m_wstrb,
  output logic                 m_wlast,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  // AXI write response
  input  logic [AXI_ID_W-1:0]  m_bid,
  input  logic [1:0]           m_bresp,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  // response-error status
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_GAP, W_RESP} wr_state_t;

  rd_state_t   r_state, r_state_nxt;
  wr_state_t   w_state, w_state_nxt;
  logic [8:0]  r_beat;
  logic [7:0]  w_beat;
  logic        r_accept, r_hs, r_len_err;
  logic        w_accept, w_hs, w_last, b_hs;

  assign m_arid    = AXI_ID_W'(RD_ID);
  assign m_awid    = AXI_ID_W'(WR_ID);
  assign m_arsize  = 3'b010;
  assign m_awsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_awburst = 2'b01;

  // A request is not taken while the previous burst's final pulse is still
  // visible: the arbiter only drops its level-held request after seeing it.
  assign r_accept  = (r_state == R_IDLE) && ce_i && ren_i && !rdata_valid_o;
  assign r_hs      = (r_state == R_DATA) && m_rvalid;
  assign r_len_err = r_hs && m_rlast && (r_beat != {1'b0, m_arlen});

  assign w_accept  = (w_state == W_IDLE) && ce_i && wen_i && !wdata_resp_o;
  assign w_hs      = (w_state == W_DATA) && m_wready;
  assign w_last    = (w_beat == m_awlen);
  assign b_hs      = (w_state == W_RESP) && m_bvalid;

  assign m_wdata   = wdata_i;
  assign m_wstrb   = wsel_i;

  // Read and write state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_state_nxt;
      w_state <= w_state_nxt;
    end
  end

  // Read next state and AR/R handshake outputs
  always_comb begin
    r_state_nxt = r_state;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    case (r_state)
      R_IDLE: if (r_accept) r_state_nxt = R_ADDR;
      R_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid && m_rlast) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Write next state and AW/W/B handshake outputs
  always_comb begin
    w_state_nxt = w_state;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;
    case (w_state)
      W_IDLE: if (w_accept) w_state_nxt = W_ADDR;
      W_ADDR: begin
        m_awvalid = 1'b1;
        if (m_awready) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        m_wvalid = 1'b1;
        m_wlast  = w_last;
        if (m_wready) w_state_nxt = w_last ? W_RESP : W_GAP;
      end
      W_GAP: w_state_nxt = W_DATA;
      W_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Request capture and beat counters; restarted on every accepted request
  always_ff @(posedge clk) begin
    if (r_accept) begin
      m_araddr <= raddr_i;
      m_arlen  <= rlen_i;
      r_beat   <= '0;
    end else if (r_hs) begin
      r_beat   <= r_beat + 9'd1;
    end
    if (w_accept) begin
      m_awaddr <= waddr_i;
      m_awlen  <= wlen_i;
      w_beat   <= '0;
    end else if (w_hs && !w_last) begin
      w_beat   <= w_beat + 8'd1;
    end
  end

  // Registered per-beat pulses: read data, and write completions (the gap
  // cycle after each non-final beat, and the cycle after B for the final one)
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      wdata_resp_o  <= 1'b0;
    end else begin
      rdata_valid_o <= r_hs;
      if (r_hs) rdata_o <= m_rdata;
      wdata_resp_o  <= (w_hs && !w_last) || b_hs;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{rready_i, wlast_i, wvalid_i, m_rid, m_bid};

`ifdef AXI_BRIDGE_ERR_CNT_EN
  logic [2:0] err_inc;
  assign err_inc = 3'(r_hs & m_rresp[1]) + 3'(r_len_err) + 3'(b_hs & m_bresp[1]);

  function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                   input logic [2:0]           inc);
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, a} + {{(ERR_CNT_W-2){1'b0}}, inc};
    return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
  endfunction

  // Sticky error flag and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      if (err_inc != 3'd0) err_o <= 1'b1;
      err_cnt_o <= sat_add(err_cnt_o, err_inc);
    end
  end

  logic unused_resp;
  assign unused_resp = ^{m_rresp[0], m_bresp[0]};
`else
  assign err_o     = 1'b0;
  assign err_cnt_o = '0;

  logic unused_resp;
  assign unused_resp = ^{m_rresp, m_bresp, r_len_err};
`endif

endmodule

// File: tb/tb_axi_master_bridge.sv
// Self-checking bench for axi_master_bridge: bench-side AXI slave tasks,
// an upstream write-data model that steps on each completion pulse, and
// per-scenario tasks comparing against expectations built from burst rules.
module tb_axi_master_bridge;
  logic        clk = 1'b0;
  logic        rst, ce_i;
  logic        ren_i, rready_i;
  logic [31:0] raddr_i;
  logic [7:0]  rlen_i;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        wen_i, wlast_i, wvalid_i;
  logic [31:0] waddr_i, wdata_i;
  logic [3:0]  wsel_i;
  logic [7:0]  wlen_i;
  logic        wdata_resp_o;
  logic [3:0]  m_arid, m_rid, m_awid, m_bid;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        err_o;
  logic [15:0] err_cnt_o;

  axi_master_bridge dut (
    .clk(clk), .rst(rst), .ce_i(ce_i),
    .ren_i(ren_i), .raddr_i(raddr_i), .rlen_i(rlen_i), .rready_i(rready_i),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .wen_i(wen_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wsel_i(wsel_i),
    .wlen_i(wlen_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wdata_resp_o(wdata_resp_o),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // observations gathered by the monitor
  logic [31:0] rd_got[$];
  logic [36:0] wbeat_q[$];
  int          wbeat_cyc[$];
  int          resp_cyc[$];
  logic [31:0] wr_words[16];
  int          wr_base = 0;

  // observations returned by the slave tasks
  logic [31:0] obs_araddr, obs_awaddr;
  logic [7:0]  obs_arlen, obs_awlen;
  logic        obs_ar_held, obs_aw_held, obs_bready;
  int          obs_wq_at_aw;
  int          b_cyc;
  int          rd_tmo, w_tmo;

  // Monitor, plus the upstream model that presents word[n] after n completions
  always @(negedge clk) begin
    if (rdata_valid_o) rd_got.push_back(rdata_o);
    if (m_wvalid && m_wready) begin
      wbeat_q.push_back({m_wlast, m_wstrb, m_wdata});
      wbeat_cyc.push_back(cyc);
    end
    if (wdata_resp_o) resp_cyc.push_back(cyc);
    wdata_i = wr_words[(resp_cyc.size() - wr_base) & 15];
  end

  task automatic rd_slave(input int ar_dly, input int n, input logic [31:0] base, input int err_idx);
    int t;
    t = 0;
    while (!m_arvalid && t < 100) begin @(negedge clk); t++; end
    if (!m_arvalid) begin rd_tmo++; return; end
    obs_ar_held = 1'b1;
    repeat (ar_dly) begin @(negedge clk); if (!m_arvalid) obs_ar_held = 1'b0; end
    obs_araddr = m_araddr;
    obs_arlen  = m_arlen;
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      m_rvalid = 1'b1;
      m_rdata  = base + k;
      m_rlast  = (k == n - 1);
      m_rresp  = (k == err_idx) ? 2'b10 : 2'b00;
      t = 0;
      while (!m_rready && t < 50) begin @(negedge clk); t++; end
      if (!m_rready) begin rd_tmo++; m_rvalid = 1'b0; m_rlast = 1'b0; return; end
      @(negedge clk);
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
    end
  endtask

  task automatic wr_slave(input int aw_dly, input int b_dly, input logic [1:0] bresp);
    int t;
    t = 0;
    while (!m_awvalid && t < 100) begin @(negedge clk); t++; end
    if (!m_awvalid) begin w_tmo++; return; end
    obs_aw_held = 1'b1;
    repeat (aw_dly) begin @(negedge clk); if (!m_awvalid) obs_aw_held = 1'b0; end
    obs_awaddr   = m_awaddr;
    obs_awlen    = m_awlen;
    obs_wq_at_aw = wbeat_q.size();
    m_awready = 1'b1;
    @(negedge clk);
    m_awready = 1'b0;
    t = 0;
    while (!(m_wvalid && m_wlast) && t < 1000) begin @(negedge clk); t++; end
    if (!(m_wvalid && m_wlast)) begin w_tmo++; return; end
    repeat (b_dly) @(negedge clk);
    obs_bready = m_bready;
    b_cyc    = cyc;
    m_bvalid = 1'b1;
    m_bresp  = bresp;
    @(negedge clk);
    m_bvalid = 1'b0; m_bresp = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_i = 1'b1; ren_i = 1'b0; rready_i = 1'b1; raddr_i = '0; rlen_i = '0;
    wen_i = 1'b0; waddr_i = '0; wsel_i = '0; wlen_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b1; m_bid = 4'd1; m_bresp = '0; m_bvalid = 1'b0;
    for (int k = 0; k < 16; k++) wr_words[k] = '0;
    repeat (3) @(negedge clk);
    total++; if (rdata_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b exp=0", rdata_valid_o); end
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", rdata_o); end
    total++; if (wdata_resp_o !== 1'b0) begin bad++; $display("FAIL rst_wresp got=%0b exp=0", wdata_resp_o); end
    total++;
    if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready} !== 5'b0) begin
      bad++; $display("FAIL rst_handshakes got=%0b exp=0", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready});
    end
    total++; if ({err_o, err_cnt_o} !== 17'h0) begin bad++; $display("FAIL rst_err got=%0h exp=0", {err_o, err_cnt_o}); end
    total++;
    if ({m_arid, m_awid, m_arsize, m_awsize, m_arburst, m_awburst} !== {4'd0, 4'd1, 3'b010, 3'b010, 2'b01, 2'b01}) begin
      bad++; $display("FAIL axi_consts got=%0h exp=%0h", {m_arid, m_awid, m_arsize, m_awsize, m_arburst, m_awburst},
                      {4'd0, 4'd1, 3'b010, 3'b010, 2'b01, 2'b01});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_burst();
    for (int it = 0; it < 6; it++) begin
      logic [31:0] addr, base;
      int len, dly, rb;
      if (it == 0) begin addr = 32'h1C000010; len = 3; dly = 2; base = 32'hA0; end
      else begin addr = $urandom; len = $urandom_range(0, 7); dly = $urandom_range(0, 3); base = $urandom; end
      rb = rd_got.size(); rd_tmo = 0;
      raddr_i = addr; rlen_i = 8'(len); ren_i = 1'b1;
      rd_slave(dly, len + 1, base, -1);
      ren_i = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (rd_tmo !== 0) begin bad++; $display("FAIL rd%0d_timeout got=%0d exp=0", it, rd_tmo); end
      total++; if (obs_araddr !== addr) begin bad++; $display("FAIL rd%0d_araddr got=%0h exp=%0h", it, obs_araddr, addr); end
      total++; if (obs_arlen !== 8'(len)) begin bad++; $display("FAIL rd%0d_arlen got=%0d exp=%0d", it, obs_arlen, len); end
      total++; if (obs_ar_held !== 1'b1) begin bad++; $display("FAIL rd%0d_ar_held got=%0b exp=1", it, obs_ar_held); end
      total++; if (rd_got.size() - rb !== len + 1) begin bad++; $display("FAIL rd%0d_count got=%0d exp=%0d", it, rd_got.size() - rb, len + 1); end
      for (int k = 0; k <= len && rb + k < rd_got.size(); k++) begin
        total++;
        if (rd_got[rb + k] !== base + k) begin bad++; $display("FAIL rd%0d_data%0d got=%0h exp=%0h", it, k, rd_got[rb + k], base + k); end
      end
      total++; if ({m_arvalid, m_rready} !== 2'b00) begin bad++; $display("FAIL rd%0d_idle got=%0b exp=0", it, {m_arvalid, m_rready}); end
    end
  endtask

  task automatic test_write_burst();
    for (int it = 0; it < 6; it++) begin
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [36:0] beat;
      int len, awdly, bdly, wb, pb;
      addr = $urandom;
      if (it == 0) begin len = 3; sel = 4'hF; awdly = 0; bdly = 3; end
      else begin len = $urandom_range(0, 7); sel = 4'($urandom); awdly = $urandom_range(0, 3); bdly = $urandom_range(1, 4); end
      for (int k = 0; k < 16; k++) wr_words[k] = $urandom;
      wb = wbeat_q.size(); pb = resp_cyc.size(); wr_base = pb; w_tmo = 0;
      waddr_i = addr; wlen_i = 8'(len); wsel_i = sel; wen_i = 1'b1;
      wr_slave(awdly, bdly, 2'b00);
      wen_i = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (w_tmo !== 0) begin bad++; $display("FAIL wr%0d_timeout got=%0d exp=0", it, w_tmo); end
      total++; if (obs_awaddr !== addr) begin bad++; $display("FAIL wr%0d_awaddr got=%0h exp=%0h", it, obs_awaddr, addr); end
      total++; if (obs_awlen !== 8'(len)) begin bad++; $display("FAIL wr%0d_awlen got=%0d exp=%0d", it, obs_awlen, len); end
      total++; if (obs_aw_held !== 1'b1) begin bad++; $display("FAIL wr%0d_aw_held got=%0b exp=1", it, obs_aw_held); end
      total++; if (obs_wq_at_aw !== wb) begin bad++; $display("FAIL wr%0d_early_w got=%0d exp=%0d", it, obs_wq_at_aw - wb, 0); end
      total++; if (obs_bready !== 1'b1) begin bad++; $display("FAIL wr%0d_bready got=%0b exp=1", it, obs_bready); end
      total++; if (wbeat_q.size() - wb !== len + 1) begin bad++; $display("FAIL wr%0d_beats got=%0d exp=%0d", it, wbeat_q.size() - wb, len + 1); end
      for (int k = 0; k <= len && wb + k < wbeat_q.size(); k++) begin
        beat = wbeat_q[wb + k];
        total++;
        if (beat !== {(k == len), sel, wr_words[k]}) begin
          bad++; $display("FAIL wr%0d_beat%0d got=%0h exp=%0h", it, k, beat, {(k == len), sel, wr_words[k]});
        end
        if (k > 0) begin
          total++;
          if (wbeat_cyc[wb + k] - wbeat_cyc[wb + k - 1] !== 2) begin
            bad++; $display("FAIL wr%0d_gap%0d got=%0d exp=2", it, k, wbeat_cyc[wb + k] - wbeat_cyc[wb + k - 1]);
          end
        end
      end
      total++; if (resp_cyc.size() - pb !== len + 1) begin bad++; $display("FAIL wr%0d_resps got=%0d exp=%0d", it, resp_cyc.size() - pb, len + 1); end
      if (resp_cyc.size() > pb) begin
        total++;
        if (resp_cyc[resp_cyc.size() - 1] !== b_cyc + 1) begin
          bad++; $display("FAIL wr%0d_last_resp got=%0d exp=%0d", it, resp_cyc[resp_cyc.size() - 1], b_cyc + 1);
        end
        for (int k = pb; k < resp_cyc.size() - 1; k++) begin
          total++; if (resp_cyc[k] >= b_cyc) begin bad++; $display("FAIL wr%0d_early_resp got=%0d exp<%0d", it, resp_cyc[k], b_cyc); end
        end
      end
    end
  endtask

  task automatic test_single_write();
    logic [36:0] beat;
    int wb, pb;
    wr_words[0] = 32'h0000BEEF;
    wb = wbeat_q.size(); pb = resp_cyc.size(); wr_base = pb; w_tmo = 0;
    waddr_i = 32'h4000_0100; wlen_i = 8'd0; wsel_i = 4'h3; wen_i = 1'b1;
    wr_slave(1, 2, 2'b00);
    wen_i = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (w_tmo !== 0) begin bad++; $display("FAIL single_timeout got=%0d exp=0", w_tmo); end
    total++; if (wbeat_q.size() - wb !== 1) begin bad++; $display("FAIL single_beats got=%0d exp=1", wbeat_q.size() - wb); end
    if (wbeat_q.size() > wb) begin
      beat = wbeat_q[wb];
      total++; if (beat !== {1'b1, 4'h3, 32'h0000BEEF}) begin bad++; $display("FAIL single_beat got=%0h exp=%0h", beat, {1'b1, 4'h3, 32'h0000BEEF}); end
    end
    total++; if (resp_cyc.size() - pb !== 1) begin bad++; $display("FAIL single_resps got=%0d exp=1", resp_cyc.size() - pb); end
    if (resp_cyc.size() > pb) begin
      total++; if (resp_cyc[pb] !== b_cyc + 1) begin bad++; $display("FAIL single_resp_time got=%0d exp=%0d", resp_cyc[pb], b_cyc + 1); end
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] rbase;
    logic [36:0] beat;
    int rb, wb, pb;
    rbase = $urandom;
    for (int k = 0; k < 16; k++) wr_words[k] = $urandom;
    rb = rd_got.size(); wb = wbeat_q.size(); pb = resp_cyc.size(); wr_base = pb;
    rd_tmo = 0; w_tmo = 0;
    raddr_i = 32'h1000_0040; rlen_i = 8'd3; ren_i = 1'b1;
    waddr_i = 32'h2000_0080; wlen_i = 8'd3; wsel_i = 4'hA; wen_i = 1'b1;
    fork
      rd_slave(1, 4, rbase, -1);
      wr_slave(0, 2, 2'b00);
    join
    ren_i = 1'b0; wen_i = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (rd_tmo + w_tmo !== 0) begin bad++; $display("FAIL cc_timeout got=%0d exp=0", rd_tmo + w_tmo); end
    total++; if (obs_araddr !== 32'h1000_0040) begin bad++; $display("FAIL cc_araddr got=%0h exp=10000040", obs_araddr); end
    total++; if (obs_awaddr !== 32'h2000_0080) begin bad++; $display("FAIL cc_awaddr got=%0h exp=20000080", obs_awaddr); end
    total++; if (rd_got.size() - rb !== 4) begin bad++; $display("FAIL cc_rd_count got=%0d exp=4", rd_got.size() - rb); end
    for (int k = 0; k < 4 && rb + k < rd_got.size(); k++) begin
      total++; if (rd_got[rb + k] !== rbase + k) begin bad++; $display("FAIL cc_rd_data%0d got=%0h exp=%0h", k, rd_got[rb + k], rbase + k); end
    end
    total++; if (wbeat_q.size() - wb !== 4) begin bad++; $display("FAIL cc_wr_beats got=%0d exp=4", wbeat_q.size() - wb); end
    for (int k = 0; k < 4 && wb + k < wbeat_q.size(); k++) begin
      beat = wbeat_q[wb + k];
      total++; if (beat !== {(k == 3), 4'hA, wr_words[k]}) begin bad++; $display("FAIL cc_wr_beat%0d got=%0h exp=%0h", k, beat, {(k == 3), 4'hA, wr_words[k]}); end
    end
    total++; if (resp_cyc.size() - pb !== 4) begin bad++; $display("FAIL cc_resps got=%0d exp=4", resp_cyc.size() - pb); end
  endtask

  task automatic test_ce();
    logic seen;
    logic [31:0] base;
    int rb, t;
    seen = 1'b0;
    ce_i = 1'b0; ren_i = 1'b1; wen_i = 1'b1; raddr_i = 32'h100; rlen_i = 8'd0; wlen_i = 8'd0;
    repeat (6) begin @(negedge clk); if (m_arvalid || m_awvalid || wdata_resp_o) seen = 1'b1; end
    ren_i = 1'b0; wen_i = 1'b0; ce_i = 1'b1;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ce_block got=%0b exp=0", seen); end
    rb = rd_got.size(); base = $urandom; rd_tmo = 0;
    raddr_i = 32'h2000; rlen_i = 8'd1; ren_i = 1'b1;
    fork
      rd_slave(0, 2, base, -1);
      begin
        t = 0;
        while (!m_rready && t < 100) begin @(negedge clk); t++; end
        ce_i = 1'b0;
      end
    join
    ren_i = 1'b0;
    repeat (3) @(negedge clk);
    ce_i = 1'b1;
    total++; if (rd_tmo !== 0) begin bad++; $display("FAIL ce_timeout got=%0d exp=0", rd_tmo); end
    total++; if (rd_got.size() - rb !== 2) begin bad++; $display("FAIL ce_count got=%0d exp=2", rd_got.size() - rb); end
    if (rd_got.size() - rb >= 2) begin
      total++; if (rd_got[rb + 1] !== base + 1) begin bad++; $display("FAIL ce_data got=%0h exp=%0h", rd_got[rb + 1], base + 1); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] base;
    int rb, t;
    rb = rd_got.size(); rd_tmo = 0;
    raddr_i = 32'h3000_0000; rlen_i = 8'd3; ren_i = 1'b1;
    t = 0;
    while (!m_arvalid && t < 100) begin @(negedge clk); t++; end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_rvalid = 1'b1; m_rdata = 32'h5000 + k; m_rlast = 1'b0;
      @(negedge clk);
    end
    m_rvalid = 1'b0;
    rst = 1'b1; ren_i = 1'b0;
    @(negedge clk);
    total++; if (rdata_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_rvalid got=%0b exp=0", rdata_valid_o); end
    total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata got=%0h exp=0", rdata_o); end
    total++;
    if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, wdata_resp_o, err_o} !== 7'b0) begin
      bad++; $display("FAIL mid_rst_ctrl got=%0b exp=0", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, wdata_resp_o, err_o});
    end
    rst = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hDEAD;
    repeat (3) @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rd_got.size() - rb !== 2) begin bad++; $display("FAIL mid_rst_pulses got=%0d exp=2", rd_got.size() - rb); end
    rb = rd_got.size(); base = $urandom;
    raddr_i = 32'h3000_1000; rlen_i = 8'd0; ren_i = 1'b1;
    rd_slave(0, 1, base, -1);
    ren_i = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rd_tmo !== 0) begin bad++; $display("FAIL post_rst_timeout got=%0d exp=0", rd_tmo); end
    total++; if (rd_got.size() - rb !== 1) begin bad++; $display("FAIL post_rst_count got=%0d exp=1", rd_got.size() - rb); end
    if (rd_got.size() > rb) begin
      total++; if (rd_got[rb] !== base) begin bad++; $display("FAIL post_rst_data got=%0h exp=%0h", rd_got[rb], base); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] base;
    logic        exp_err;
    logic [15:0] exp_cnt;
    int rb, pb;
`ifdef AXI_BRIDGE_ERR_CNT_EN
    exp_err = 1'b1; exp_cnt = 16'd2;
`else
    exp_err = 1'b0; exp_cnt = 16'd0;
`endif
    total++; if ({err_o, err_cnt_o} !== 17'h0) begin bad++; $display("FAIL err_clean got=%0h exp=0", {err_o, err_cnt_o}); end
    rb = rd_got.size(); base = $urandom; rd_tmo = 0;
    raddr_i = 32'h5000_0000; rlen_i = 8'd0; ren_i = 1'b1;
    rd_slave(0, 1, base, 0);
    ren_i = 1'b0;
    @(negedge clk);
    wr_words[0] = $urandom;
    pb = resp_cyc.size(); wr_base = pb; w_tmo = 0;
    waddr_i = 32'h5000_0100; wlen_i = 8'd0; wsel_i = 4'hF; wen_i = 1'b1;
    wr_slave(0, 1, 2'b11);
    wen_i = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rd_tmo + w_tmo !== 0) begin bad++; $display("FAIL err_timeout got=%0d exp=0", rd_tmo + w_tmo); end
    total++; if (rd_got.size() - rb !== 1) begin bad++; $display("FAIL err_rd_count got=%0d exp=1", rd_got.size() - rb); end
    if (rd_got.size() > rb) begin
      total++; if (rd_got[rb] !== base) begin bad++; $display("FAIL err_rd_data got=%0h exp=%0h", rd_got[rb], base); end
    end
    total++; if (resp_cyc.size() - pb !== 1) begin bad++; $display("FAIL err_resps got=%0d exp=1", resp_cyc.size() - pb); end
    total++; if (err_cnt_o !== exp_cnt) begin bad++; $display("FAIL err_cnt got=%0d exp=%0d", err_cnt_o, exp_cnt); end
    total++; if (err_o !== exp_err) begin bad++; $display("FAIL err_flag got=%0b exp=%0b", err_o, exp_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_single_write();
    test_concurrent();
    test_ce();
    test_reset_mid_burst();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
- Converts the simple level-held burst request/beat interface driven by the cache arbiter into AXI4 master channels (AR/R/AW/W/B).
- Sits directly downstream of the cache arbiter and directly upstream of the SoC AXI interconnect.
- Reads return one registered `rdata_valid_o` pulse per beat.
- Writes return one `wdata_resp_o` pulse per beat; the final pulse is deferred to the B response, so the arbiter's beat counter selects the next data word.

Parameters:
- AXI_ID_W, 4, width of arid/awid.
- RD_ID, 0, constant ARID.
- WR_ID, 1, constant AWID.
- ERR_CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ce_i  in  1  enable; no new request is accepted while low
- ren_i / raddr_i / rlen_i / rready_i  in  1/32/8/1  read request, held until its final beat; rready_i is advisory and ignored
- rdata_o / rdata_valid_o  out  32/1  registered read beat
- wen_i / waddr_i / wdata_i / wsel_i / wlen_i / wlast_i / wvalid_i  in  1/32/32/4/8/1/1  write request and current beat; wlast_i and wvalid_i are ignored
- wdata_resp_o  out  1  per-beat write completion pulse
- m_arid/araddr/arlen/arsize/arburst/arvalid  out  AXI_ID_W/32/8/3/2/1
- m_arready  in  1
- m_rid/rdata/rresp/rlast/rvalid  in  AXI_ID_W/32/2/1/1
- m_rready  out  1
- m_awid/awaddr/awlen/awsize/awburst/awvalid  out  AXI_ID_W/32/8/3/2/1
- m_awready  in  1
- m_wdata/wstrb/wlast/wvalid  out  32/4/1/1
- m_wready  in  1
- m_bid/bresp/bvalid  in  AXI_ID_W/2/1
- m_bready  out  1
- err_o / err_cnt_o  out  1/ERR_CNT_W  response-error status

Behaviour:
- Constants:
  - arsize = awsize = 3'b010
  - arburst = awburst = 2'b01 (INCR)
  - arid = RD_ID, awid = WR_ID
- Read and write FSMs are independent and may run concurrently.
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE:
    - If ce_i & ren_i, latch raddr_i/rlen_i into araddr/arlen, clear beat counter, go to R_ADDR.
    - Requests are sampled only in R_IDLE.
  - R_ADDR:
    - arvalid = 1; addr/len held stable.
    - On arready, go to R_DATA. arvalid must not drop before arready.
  - R_DATA:
    - m_rready = 1.
    - On each rvalid & rready: rdata_o <= m_rdata and rdata_valid_o <= 1 for exactly one cycle (next edge); beat counter +1.
    - Go to R_IDLE on the handshake with rlast = 1.
    - A beat-count mismatch with arlen+1 is an error event. The FSM still follows rlast.
  - rdata_valid_o is low in every other cycle.
  - Minimum AR->first-data latency is 1 cycle after the R handshake.
  - Back-to-back bursts need at least one R_IDLE cycle.
- Write FSM W_IDLE -> W_ADDR -> W_DATA <-> W_GAP -> W_RESP -> W_IDLE:
  - W_IDLE:
    - If ce_i & wen_i, latch waddr_i/wlen_i, set beat counter = 0, go to W_ADDR.
    - Write has no priority over read.
  - W_ADDR:
    - awvalid = 1 until awready, then go to W_DATA. Data is not sent before AW is accepted.
  - W_DATA:
    - m_wvalid = 1; m_wdata = wdata_i and m_wstrb = wsel_i, both combinational.
    - m_wlast = (beat == awlen).
    - On a non-last handshake: beat +1, go to W_GAP.
    - On the last handshake: go to W_RESP.
  - W_GAP:
    - wvalid = 0; wdata_resp_o = 1 for this one cycle. Upstream advances its data select this cycle.
    - Go to W_DATA.
  - W_RESP:
    - m_bready = 1.
    - On bvalid: wdata_resp_o pulses 1 cycle (registered), go to W_IDLE.
  - A write of awlen = N produces exactly N+1 wdata_resp_o pulses. The last pulse always follows B.
- Reset values:
  - All valids/readys, rdata_valid_o, wdata_resp_o and err_o are 0.
  - rdata_o = 0, err_cnt_o = 0, both FSMs idle.
- rst mid-burst abandons the transaction immediately; no further pulses are produced.
- ce_i low during an active burst does not abort it.
- rresp/bresp are never used to suppress data or pulses.

Optional Feature:
- Macro: AXI_BRIDGE_ERR_CNT_EN.
- When defined:
  - These events are each one error: an R beat with rresp[1] = 1, a B with bresp[1] = 1, or a read beat-count mismatch.
  - err_cnt_o increments by 1 per error and saturates at all-ones.
  - err_o is sticky high from the cycle after the first error until rst.
  - If a read error and a write error occur in the same cycle, the counter increments by 2 (still saturating).
- When undefined: err_o and err_cnt_o are tied to 0 and no counter logic exists.

Test Plan:
- Read burst:
  - Stimulus: ren_i = 1, raddr = 0x1C000010, rlen = 3; arready delayed 2 cycles; 4 beats 0xA0..0xA3 with rvalid gaps.
  - Response: araddr = 0x1C000010, arlen = 3; exactly 4 rdata_valid_o pulses carrying 0xA0..0xA3 in order; R_IDLE after rlast.
- Write burst:
  - Stimulus: wlen = 3, wsel = 0xF, wdata_i stepped by upstream on each resp; wready always 1; bvalid 3 cycles after wlast.
  - Response: W beats separated by 1-cycle gaps; m_wlast only on the 4th beat; 4 resp pulses, the 4th one cycle after bvalid.
- Uncached single write:
  - Stimulus: wlen = 0, wsel = 0x3, wdata = 0x0000BEEF.
  - Response: one W beat with wstrb = 0x3 and wlast = 1; a single resp pulse, after B only.
- Concurrent traffic:
  - Stimulus: read (rlen = 3) and write (wlen = 3) issued in the same cycle.
  - Response: both complete with correct data and counts; no cross-channel pulses.
- Reset mid-burst:
  - Stimulus: rst asserted after the 2nd read beat.
  - Response: next cycle all outputs are at reset values; a following read with rlen = 0 completes normally.
- AXI_BRIDGE_ERR_CNT_EN defined:
  - Stimulus: one rresp = 2'b10 beat and one bresp = 2'b11.
  - Response: err_cnt_o = 2, err_o = 1; data and pulses are unaffected.
